// File: rtl/prbs_pkg.sv
// Shared types and widths for the PRBS checker.
package prbs_pkg;

  // Checker phases: load history, hunt for a clean run, then track the stream.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Saturating counter widths.
  localparam int BIT_CNT_W = 32;
  localparam int ERR_CNT_W = 16;

  // Run/bad counters only need to reach thresholds in 1..255.
  localparam int RUN_CNT_W = 8;

  // Fill counter only needs to reach NUM_BITS (max 32).
  localparam int FILL_CNT_W = 6;

endpackage

// File: rtl/prbs_predict.sv
// History register and next-bit predictor for the PRBS checker.
// hist[0] is the most recent bit; the prediction is the tap XOR of history.
module prbs_predict #(
  parameter int                  NUM_BITS = 5,
  parameter logic [NUM_BITS-1:0] TAPS     = 5'h12
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_en,      // one valid bit consumed this cycle
  input  logic use_expected,  // free-run: shift the prediction instead of in_bit
  input  logic in_bit,
  output logic expected
);

  logic [NUM_BITS-1:0] hist;
  logic                shift_val;

  assign expected  = ^(hist & TAPS);
  assign shift_val = use_expected ? expected : in_bit;

  // Shift the selected bit into the history on each consumed bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
    end else if (shift_en) begin
      hist <= {hist[NUM_BITS-2:0], shift_val};
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: fills history from the incoming stream,
// waits for LOCK_COUNT consecutive correct predictions, then free-runs the
// reference and counts checked bits and errors. Lock is dropped when the
// leaky bad-bit count reaches LOSS_THRESH.
// Handshake: a bit is consumed on every rising edge where in_valid=1; there
// is no backpressure and in_valid=0 cycles leave all state untouched.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int                  NUM_BITS    = 5,
  parameter logic [NUM_BITS-1:0] TAPS        = 5'h12,
  parameter int                  LOCK_COUNT  = 16,
  parameter int                  LOSS_THRESH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_bit,
  input  logic                 in_valid,
  input  logic                 clear_counts,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [BIT_CNT_W-1:0] bit_count,
  output logic [ERR_CNT_W-1:0] err_count,
  output state_e               state_dbg
);

  localparam logic [FILL_CNT_W-1:0] FILL_LAST = FILL_CNT_W'(NUM_BITS - 1);
  localparam logic [RUN_CNT_W-1:0]  RUN_LAST  = RUN_CNT_W'(LOCK_COUNT - 1);
  localparam logic [RUN_CNT_W-1:0]  BAD_LAST  = RUN_CNT_W'(LOSS_THRESH - 1);

  state_e                state_q, state_d;
  logic [FILL_CNT_W-1:0] fill_q, fill_d;
  logic [RUN_CNT_W-1:0]  run_q, run_d;
  logic [RUN_CNT_W-1:0]  bad_q, bad_d;
  logic                  expected;
  logic                  mismatch;
  logic                  count_en;

  prbs_predict #(
    .NUM_BITS (NUM_BITS),
    .TAPS     (TAPS)
  ) u_predict (
    .clk          (clk),
    .rst          (rst),
    .shift_en     (in_valid),
    .use_expected (state_q == LOCKED),
    .in_bit       (in_bit),
    .expected     (expected)
  );

  assign mismatch  = in_valid && (in_bit != expected);
  assign count_en  = in_valid && (state_q == LOCKED);
  assign locked    = (state_q == LOCKED);
  assign state_dbg = state_q;

  // Next-state and fill/run/bad counter updates for each consumed bit.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    run_d   = run_q;
    bad_d   = bad_q;
    if (in_valid) begin
      case (state_q)
        FILL: begin
          fill_d = fill_q + 1'b1;
          if (fill_q == FILL_LAST) begin
            state_d = SYNC;
            run_d   = '0;
          end
        end
        SYNC: begin
          if (mismatch) begin
            run_d = '0;
          end else begin
            run_d = run_q + 1'b1;
            if (run_q == RUN_LAST) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end
        end
        LOCKED: begin
          if (mismatch) begin
            bad_d = bad_q + 1'b1;
            if (bad_q == BAD_LAST) begin
              state_d = FILL;
              fill_d  = '0;
            end
          end else if (bad_q != '0) begin
            bad_d = bad_q - 1'b1;
          end
        end
        default: begin
          state_d = FILL;
          fill_d  = '0;
        end
      endcase
    end
  end

  // FSM state and internal counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      fill_q  <= '0;
      run_q   <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      run_q   <= run_d;
      bad_q   <= bad_d;
    end
  end

  // Error pulse and saturating statistics; clear_counts beats a counted bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse <= 1'b0;
      bit_count <= '0;
      err_count <= '0;
    end else begin
      err_pulse <= count_en && mismatch;
      if (clear_counts) begin
        bit_count <= '0;
        err_count <= '0;
      end else begin
        if (count_en && (bit_count != '1)) bit_count <= bit_count + 1'b1;
        if (count_en && mismatch && (err_count != '1)) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: an in-bench LFSR drives the stream, a behavioural
// model predicts every output each cycle, plus directed lock/error checks.
module tb_prbs_checker;
  import prbs_pkg::*;

  localparam int         NB    = 5;
  localparam logic [4:0] TAPS  = 5'h12;
  localparam int         LOCK  = 16;
  localparam int         LOSS  = 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        clear_counts = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [31:0] bit_count;
  logic [15:0] err_count;
  state_e      state_dbg;

  always #5 clk = ~clk;

  prbs_checker #(
    .NUM_BITS    (NB),
    .TAPS        (TAPS),
    .LOCK_COUNT  (LOCK),
    .LOSS_THRESH (LOSS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_bit       (in_bit),
    .in_valid     (in_valid),
    .clear_counts (clear_counts),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .bit_count    (bit_count),
    .err_count    (err_count),
    .state_dbg    (state_dbg)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus generator (Fibonacci LFSR) ----------------
  logic [4:0] g_sr   = 5'd1;
  logic [4:0] g_taps = 5'h12;

  // ---------------- behavioural reference model ----------------
  // Stream view: bits[] holds recent bits, newest first; the prediction is
  // XOR over i of TAPS[i] & b[t-1-i].
  int          m_mode;   // 0 filling, 1 hunting, 2 locked
  int          m_fill, m_run, m_bad;
  logic        m_locked, m_pulse;
  logic [31:0] m_bits;
  logic [15:0] m_errs;
  logic        m_hist[$];
  logic [49:0] exp_q[$];

  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_run = 0; m_bad = 0;
    m_bits = '0; m_errs = '0; m_pulse = 1'b0;
    m_hist.delete();
    for (int i = 0; i < NB; i++) m_hist.push_back(1'b0);
  endtask

  function automatic logic predict();
    logic e = 1'b0;
    for (int i = 0; i < NB; i++) if (TAPS[i]) e ^= m_hist[i];
    return e;
  endfunction

  task automatic push_hist(input logic b);
    m_hist.push_front(b);
    void'(m_hist.pop_back());
  endtask

  task automatic model_step(input logic v, input logic b, input logic clr, input logic r);
    logic e;
    m_pulse = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      if (v) begin
        e = predict();
        case (m_mode)
          0: begin
            push_hist(b);
            m_fill++;
            if (m_fill == NB) begin m_mode = 1; m_run = 0; end
          end
          1: begin
            if (b == e) m_run++; else m_run = 0;
            push_hist(b);
            if (m_run == LOCK) begin m_mode = 2; m_bad = 0; end
          end
          default: begin
            if (m_bits != 32'hFFFF_FFFF) m_bits++;
            if (b != e) begin
              m_pulse = 1'b1;
              if (m_errs != 16'hFFFF) m_errs++;
              m_bad++;
              if (m_bad == LOSS) begin m_mode = 0; m_fill = 0; end
            end else if (m_bad > 0) begin
              m_bad--;
            end
            push_hist(e);
          end
        endcase
      end
      if (clr) begin m_bits = '0; m_errs = '0; end
    end
    m_locked = (m_mode == 2);
    exp_q.push_back({m_locked, m_pulse, m_errs, m_bits});
  endtask

  // ---------------- driver tasks ----------------
  // One clock: apply inputs, step model at the edge, compare 1 time unit later.
  task automatic cycle(input logic v, input logic b, input logic clr, input logic r);
    logic [49:0] e;
    in_valid = v; in_bit = b; clear_counts = clr; rst = r;
    @(posedge clk);
    model_step(v, b, clr, r);
    #1;
    e = exp_q.pop_front();
    check("locked", 32'(locked), 32'(e[49]));
    check("err_pulse", 32'(err_pulse), 32'(e[48]));
    check("err_count", 32'(err_count), 32'(e[47:32]));
    check("bit_count", bit_count, e[31:0]);
  endtask

  // Send the next generator bit (optionally inverted) or an idle cycle.
  task automatic send(input logic flip, input logic v, input logic clr, input logic r);
    logic b;
    if (v) begin
      b    = g_sr[4] ^ flip;
      g_sr = {g_sr[3:0], ^(g_sr & g_taps)};
    end else begin
      b = 1'($urandom_range(0, 1));
    end
    cycle(v, b, clr, r);
  endtask

  task automatic do_reset(input logic [4:0] seed, input logic [4:0] taps);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    rst    = 1'b0;
    g_sr   = seed;
    g_taps = taps;
  endtask

  // Run until locked; pattern 0 = valid every cycle, 1 = valid on even cycles.
  task automatic run_until_lock(input int pattern, output int nvalid, output int ncyc);
    nvalid = 0; ncyc = -1;
    for (int c = 1; c <= 400; c++) begin
      logic v;
      v = (pattern == 0) ? 1'b1 : ((c % 2) == 0);
      if (v) nvalid++;
      send(1'b0, v, 1'b0, 1'b0);
      if (locked) begin ncyc = c; break; end
    end
    if (ncyc < 0) nvalid = -1;
  endtask

  // ---------------- test sequence ----------------
  int nv, nc, p, lk, burst;
  logic [31:0] bits0;

  initial begin
    model_reset();
    do_reset(5'd1, 5'h12);
    check("rst_state", 32'(state_dbg), 32'(FILL));

    // Clean stream: lock after 5 fill + 16 matches, then 1000 clean bits.
    run_until_lock(0, nv, nc);
    check("lock_valid_bits", nv, 21);
    bits0 = bit_count;
    for (int i = 0; i < 1000; i++) send(1'b0, 1'b1, 1'b0, 1'b0);
    check("clean_errs", 32'(err_count), 0);
    check("bit_delta", bit_count - bits0, 1000);

    // Single inverted bit: one pulse, one error, lock kept.
    p = 0;
    send(1'b1, 1'b1, 1'b0, 1'b0);
    check("single_pulse", 32'(err_pulse), 1);
    p += int'(err_pulse);
    for (int i = 0; i < 20; i++) begin
      send(1'b0, 1'b1, 1'b0, 1'b0);
      p += int'(err_pulse);
    end
    check("pulse_total", p, 1);
    check("single_err", 32'(err_count), 1);
    check("single_locked", 32'(locked), 1);

    // Eight inverted bits: lock drops on the 8th, then relock.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      send(1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 7) check("locked_before_8th", 32'(locked), 1);
    end
    check("burst_errs", 32'(err_count), 8);
    check("burst_drop", 32'(locked), 0);
    run_until_lock(0, nv, nc);
    check("relock_bits", nv, 21);

    // Alternating gaps: 21 valid bits over 42 cycles.
    do_reset(5'd1, 5'h12);
    run_until_lock(1, nv, nc);
    check("gap_cycles", nc, 42);
    check("gap_valid", nv, 21);
    check("gap_errs", 32'(err_count), 0);

    // Foreign polynomial never locks.
    do_reset(5'd1, 5'h1B);
    lk = 0;
    for (int i = 0; i < 2000; i++) begin
      send(1'b0, 1'b1, 1'b0, 1'b0);
      lk += int'(locked);
    end
    check("foreign_locked", lk, 0);

    // clear_counts with a counted bit, then reset mid-lock.
    do_reset(5'd1, 5'h12);
    run_until_lock(0, nv, nc);
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_clr_errs", 32'(err_count), 2);
    send(1'b0, 1'b1, 1'b1, 1'b0);
    check("clr_bits", bit_count, 0);
    check("clr_errs", 32'(err_count), 0);
    check("clr_locked", 32'(locked), 1);
    send(1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    check("midrst_locked", 32'(locked), 0);
    check("midrst_pulse", 32'(err_pulse), 0);
    check("midrst_bits", bit_count, 0);
    check("midrst_state", 32'(state_dbg), 32'(FILL));

    // Randomised traffic: gaps, sparse errors, bursts, clears, resets.
    g_sr  = 5'($urandom_range(1, 31));
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      logic v, f, c, r;
      v = ($urandom_range(0, 3) != 0);
      if (burst > 0) begin
        f = 1'b1; burst--;
      end else begin
        f = ($urandom_range(0, 63) == 0);
        if ($urandom_range(0, 299) == 0) burst = $urandom_range(3, 10);
      end
      c = ($urandom_range(0, 199) == 0);
      r = ($urandom_range(0, 1499) == 0);
      send(f, v, c, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side counterpart of the team's Fibonacci LFSR bit generator.
- Takes the serial pseudo-random bit stream produced by an lfsr of identical NUM_BITS/TAPS, self-synchronises to it without knowing the seed, and declares lock.
- Once locked, flags and counts bit errors.
- Used for on-board link/loopback tests on the Tang Nano 9K and as a self-checking monitor in simulation.

Parameters:
- NUM_BITS, 5, LFSR length; must match the generator; 2..32.
- TAPS, 5'h12, feedback tap mask (bit i set = state bit i feeds the XOR); must match the generator.
- LOCK_COUNT, 16, consecutive correctly predicted bits needed to declare lock; 1..255.
- LOSS_THRESH, 8, leaky bad-bit count at which lock is dropped; 1..255.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, reset; synchronous and active-high.
- in_bit, input, 1, received serial bit; sampled only when in_valid=1.
- in_valid, input, 1, qualifies in_bit; gaps of any length are allowed.
- clear_counts, input, 1, synchronous clear of bit_count and err_count only; lock state is unaffected.
- locked, output, 1, high while in LOCKED.
- err_pulse, output, 1, one-cycle pulse, registered, on each mismatching valid bit while LOCKED.
- bit_count, output, 32, valid bits checked while LOCKED; saturates at all-ones.
- err_count, output, 16, mismatches while LOCKED; saturates at 16'hFFFF.

Behaviour:
- Generator convention (fixed by this spec):
  - next state = {sr[NUM_BITS-2:0], ^(sr & TAPS)}; emitted bit = sr[NUM_BITS-1].
  - Resulting stream recurrence: b[t] = XOR over i of TAPS[i] & b[t-1-i].
- History register hist[NUM_BITS-1:0]:
  - hist[0] is the most recent bit; shift rule is hist <= {hist[NUM_BITS-2:0], x}.
  - expected = ^(hist & TAPS), computed combinationally from hist.
- Reset: state=FILL; hist, fill counter, run counter and bad counter = 0; locked=0, err_pulse=0, bit_count=0, err_count=0.
- Cycles with in_valid=0 change nothing: no state change, no shift, err_pulse=0.
- FILL:
  - Each valid bit: shift in_bit into hist and increment the fill counter. No comparison is made.
  - After the NUM_BITS-th valid bit: go to SYNC and clear the run counter.
- SYNC:
  - Each valid bit: compare in_bit with expected, then shift in_bit.
  - Match: run+1. Mismatch: run=0, stay in SYNC.
  - When a match makes run reach LOCK_COUNT: go to LOCKED and clear the bad counter. locked=1 from the following cycle.
- LOCKED:
  - Each valid bit: shift expected, not in_bit. The reference then free-runs, so each corrupted bit counts as exactly one error (no tap-based error multiplication).
  - Every valid bit: bit_count+1 (saturating).
  - Mismatch: err_pulse=1 next cycle, err_count+1 (saturating), bad+1.
  - Match: bad-1, saturating at 0.
  - When bad reaches LOSS_THRESH: go to FILL, clear the fill counter, locked=0 next cycle. The erroring bit is still counted.
- Simultaneous clear_counts and a counted bit: clear wins; counts are 0 that cycle.
- rst mid-operation: everything returns to reset values on the next edge, regardless of state.
- All-zero stream: FILL loads zeros, expected=0, so the checker locks on the stuck stream. This is documented as a known limitation; the seed must never be 0.
- Latency: locked/err_pulse/counters update one clock after the sampled bit.

Decomposition:
- Package prbs_pkg holds:
  - the state enum typedef {FILL, SYNC, LOCKED};
  - a saturating-increment width constant for the counters.
- One sub-module is natural: prbs_predict (hist register + tap XOR, shift-select between in_bit and expected).
- The FSM and counters live in prbs_checker.

Test Plan:
- lfsr(SEED=1, TAPS=5'h12, NUM_BITS=5) -> in_bit, in_valid=1 every cycle; reset then release -> locked rises exactly 1 cycle after the 21st valid bit (5 fill + 16 match); err_count stays 0 over 1000 cycles; bit_count increments by 1 per cycle.
- Same stream; invert one bit after lock -> exactly one err_pulse, err_count=1, locked stays 1.
- Invert 8 consecutive bits after lock -> err_count=8, locked drops after the 8th; then re-locks after 5+16 clean bits.
- in_valid toggled 1/0 alternately on the same stream -> lock after 21 valid bits (42 cycles); no errors.
- Mismatched generator (TAPS=5'h1B) into checker (TAPS=5'h12) -> locked never asserts in 2000 cycles.
- Assert clear_counts while locked with errors present -> bit_count=0 and err_count=0 next cycle; locked unchanged. Assert rst mid-LOCKED -> all outputs 0 next cycle.
